// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the processor, debug and dmem-side signals of the data-memory port arbiter.
// Handshake: *_req is held by the requester. An access is accepted in any cycle where
// *_req and *_gnt are both high. *_gnt is combinational, so a requester must keep its
// addr/data/wren stable for the whole cycle. *_rvalid is a one-cycle pulse qualifying *_q.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              proc_req;
  logic              proc_wren;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_data;
  logic              proc_gnt;
  logic              proc_rvalid;
  logic [DATA_W-1:0] proc_q;

  logic              dbg_req;
  logic              dbg_wren;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_q;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  proc_req, proc_wren, proc_addr, proc_data,
    output proc_gnt, proc_rvalid, proc_q,
    input  dbg_req, dbg_wren, dbg_addr, dbg_data, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_q,
    output address_dmem, data, wren,
    input  q_dmem
  );

  modport master (
    output proc_req, proc_wren, proc_addr, proc_data,
    input  proc_gnt, proc_rvalid, proc_q,
    output dbg_req, dbg_wren, dbg_addr, dbg_data, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_q,
    input  address_dmem, data, wren,
    output q_dmem
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port dmem between the processor and the debug port, one access
// per cycle, and routes read data back to whichever requester issued each read.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                proc_gnt, dbg_gnt, dbg_urgent;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wren_c;
  logic [READ_LAT-1:0] tag_vld_q, tag_own_q;
  logic                push_vld, tail_vld;
  logic                proc_rvalid, dbg_rvalid;
  logic [DATA_W-1:0]   proc_q_q, proc_q_d, dbg_q_q, dbg_q_d;

  // A starved debug port overrides the processor once it has waited MAX_WAIT cycles.
  always_comb begin
    dbg_urgent = (wait_cnt_q == MAX_WAIT_C) && bus.dbg_req;
    proc_gnt   = 1'b0;
    dbg_gnt    = 1'b0;
    if (!reset) begin
      if (bus.dbg_lock)      dbg_gnt  = bus.dbg_req;
      else if (dbg_urgent)   dbg_gnt  = 1'b1;
      else if (bus.proc_req) proc_gnt = 1'b1;
      else                   dbg_gnt  = bus.dbg_req;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.dbg_req || dbg_gnt)     wait_cnt_d = 4'd0;
    else if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wren_c = 1'b0;
    if (proc_gnt) begin
      addr_d = bus.proc_addr;
      data_d = bus.proc_data;
      wren_c = bus.proc_wren;
    end else if (dbg_gnt) begin
      addr_d = bus.dbg_addr;
      data_d = bus.dbg_data;
      wren_c = bus.dbg_wren;
    end
  end

  // Tag pipeline: valid marks a granted read, owner 1 = debug, 0 = processor.
  assign push_vld    = (proc_gnt && !bus.proc_wren) || (dbg_gnt && !bus.dbg_wren);
  assign tail_vld    = tag_vld_q[READ_LAT-1] && !reset;
  assign proc_rvalid = tail_vld && !tag_own_q[READ_LAT-1];
  assign dbg_rvalid  = tail_vld &&  tag_own_q[READ_LAT-1];
  assign proc_q_d    = proc_rvalid ? bus.q_dmem : proc_q_q;
  assign dbg_q_d     = dbg_rvalid  ? bus.q_dmem : dbg_q_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
      proc_q_q   <= '0;
      dbg_q_q    <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      proc_q_q     <= proc_q_d;
      dbg_q_q      <= dbg_q_d;
      tag_vld_q[0] <= push_vld;
      tag_own_q[0] <= dbg_gnt;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  assign bus.proc_gnt     = proc_gnt;
  assign bus.dbg_gnt      = dbg_gnt;
  assign bus.proc_rvalid  = proc_rvalid;
  assign bus.dbg_rvalid   = dbg_rvalid;
  assign bus.proc_q       = reset ? '0 : proc_q_d;
  assign bus.dbg_q        = reset ? '0 : dbg_q_d;
  assign bus.address_dmem = reset ? '0 : addr_d;
  assign bus.data         = reset ? '0 : data_d;
  assign bus.wren         = wren_c;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (READ_LAT 1 and 2) see identical stimulus
// from a vector table; read returns are checked against an expected queue per instance.
module tb_dmem_port_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int SB_W = 65;  // {due cycle[31:0], owner, data[31:0]}

  typedef struct {
    logic          rst;
    logic          preq, pwren;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata;
    logic          dreq, dwren;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddata;
    logic          dlock;
    logic          exp_pg, exp_dg;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_WAIT(MW)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));
  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .MAX_WAIT(MW)) u_dut2 (
    .clock(clock), .reset(reset), .bus(bus2.slave));

  // ---------------- dmem models ----------------
  logic [DW-1:0] mem1 [0:4095];
  logic [DW-1:0] mem2 [0:4095];
  logic [DW-1:0] m1_q, m2_p0, m2_p1;

  always @(posedge clock) begin
    if (bus1.wren) mem1[bus1.address_dmem] <= bus1.data;
    m1_q <= mem1[bus1.address_dmem];
    if (bus2.wren) mem2[bus2.address_dmem] <= bus2.data;
    m2_p0 <= mem2[bus2.address_dmem];
    m2_p1 <= m2_p0;
  end
  assign bus1.q_dmem = m1_q;
  assign bus2.q_dmem = m2_p1;

  // ---------------- scoreboard state ----------------
  logic [SB_W-1:0] exp_q1[$];
  logic [SB_W-1:0] exp_q2[$];
  logic [DW-1:0]   ref_mem [0:4095];
  logic [AW-1:0]   last_addr [2];
  logic [DW-1:0]   last_data [2];
  logic [DW-1:0]   last_pq [2];
  logic [DW-1:0]   last_dq [2];
  vec_t            vecs[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              cyc      = 0;

  task automatic chk(input string nm, input int inst, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, inst + 1, cyc, act, exp);
  endtask

  task automatic add(input logic rst, input logic preq, input logic pwren,
                     input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                     input logic dreq, input logic dwren,
                     input logic [AW-1:0] da, input logic [DW-1:0] dd,
                     input logic lock, input logic eg_p, input logic eg_d);
    vec_t v;
    v.rst = rst; v.preq = preq; v.pwren = pwren; v.paddr = pa; v.pdata = pd;
    v.dreq = dreq; v.dwren = dwren; v.daddr = da; v.ddata = dd; v.dlock = lock;
    v.exp_pg = eg_p; v.exp_dg = eg_d;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  // ---------------- driver + per-cycle checks ----------------
  task automatic run_vec(input vec_t v);
    logic          pg, dg, wr, pv, dv, hit, ew;
    logic [AW-1:0] ad, ea;
    logic [DW-1:0] da, pq, dq, ed;
    logic [SB_W-1:0] e;
    @(negedge clock);
    reset = v.rst;
    bus1.proc_req = v.preq; bus1.proc_wren = v.pwren; bus1.proc_addr = v.paddr;
    bus1.proc_data = v.pdata; bus1.dbg_req = v.dreq; bus1.dbg_wren = v.dwren;
    bus1.dbg_addr = v.daddr; bus1.dbg_data = v.ddata; bus1.dbg_lock = v.dlock;
    bus2.proc_req = v.preq; bus2.proc_wren = v.pwren; bus2.proc_addr = v.paddr;
    bus2.proc_data = v.pdata; bus2.dbg_req = v.dreq; bus2.dbg_wren = v.dwren;
    bus2.dbg_addr = v.daddr; bus2.dbg_data = v.ddata; bus2.dbg_lock = v.dlock;
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      if (inst == 0) begin
        pg = bus1.proc_gnt; dg = bus1.dbg_gnt; wr = bus1.wren; ad = bus1.address_dmem;
        da = bus1.data; pv = bus1.proc_rvalid; pq = bus1.proc_q;
        dv = bus1.dbg_rvalid; dq = bus1.dbg_q;
      end else begin
        pg = bus2.proc_gnt; dg = bus2.dbg_gnt; wr = bus2.wren; ad = bus2.address_dmem;
        da = bus2.data; pv = bus2.proc_rvalid; pq = bus2.proc_q;
        dv = bus2.dbg_rvalid; dq = bus2.dbg_q;
      end
      chk("proc_gnt", inst, DW'(pg), DW'(v.exp_pg));
      chk("dbg_gnt",  inst, DW'(dg), DW'(v.exp_dg));
      if (v.rst) begin
        last_addr[inst] = '0; last_data[inst] = '0;
        last_pq[inst] = '0;   last_dq[inst] = '0;
        if (inst == 0) exp_q1.delete(); else exp_q2.delete();
        ea = '0; ed = '0; ew = 1'b0;
      end else if (v.exp_pg) begin
        ea = v.paddr; ed = v.pdata; ew = v.pwren;
      end else if (v.exp_dg) begin
        ea = v.daddr; ed = v.ddata; ew = v.dwren;
      end else begin
        ea = last_addr[inst]; ed = last_data[inst]; ew = 1'b0;
      end
      last_addr[inst] = ea;
      last_data[inst] = ed;
      chk("wren", inst, DW'(wr), DW'(ew));
      chk("address_dmem", inst, DW'(ad), DW'(ea));
      chk("data", inst, da, ed);

      hit = 1'b0;
      e   = '0;
      if (inst == 0 && exp_q1.size() > 0 && int'(exp_q1[0][64:33]) == cyc) begin
        hit = 1'b1; e = exp_q1.pop_front();
      end else if (inst == 1 && exp_q2.size() > 0 && int'(exp_q2[0][64:33]) == cyc) begin
        hit = 1'b1; e = exp_q2.pop_front();
      end
      if (hit && e[32])  last_dq[inst] = e[31:0];
      if (hit && !e[32]) last_pq[inst] = e[31:0];
      chk("proc_rvalid", inst, DW'(pv), DW'(hit && !e[32]));
      chk("dbg_rvalid",  inst, DW'(dv), DW'(hit && e[32]));
      chk("proc_q", inst, pq, last_pq[inst]);
      chk("dbg_q",  inst, dq, last_dq[inst]);

      if (!v.rst && v.exp_pg && !v.pwren) begin
        if (inst == 0) exp_q1.push_back({32'(cyc + 1), 1'b0, ref_mem[v.paddr]});
        else           exp_q2.push_back({32'(cyc + 2), 1'b0, ref_mem[v.paddr]});
      end
      if (!v.rst && v.exp_dg && !v.dwren) begin
        if (inst == 0) exp_q1.push_back({32'(cyc + 1), 1'b1, ref_mem[v.daddr]});
        else           exp_q2.push_back({32'(cyc + 2), 1'b1, ref_mem[v.daddr]});
      end
    end
    if (!v.rst && v.exp_pg && v.pwren) ref_mem[v.paddr] = v.pdata;
    if (!v.rst && v.exp_dg && v.dwren) ref_mem[v.daddr] = v.ddata;
    cyc++;
  endtask

  // ---------------- test ----------------
  logic [DW-1:0] rnd [0:4];

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    for (int i = 0; i < 5; i++) rnd[i] = $urandom;
    bus1.proc_req = 0; bus1.proc_wren = 0; bus1.proc_addr = '0; bus1.proc_data = '0;
    bus1.dbg_req = 0; bus1.dbg_wren = 0; bus1.dbg_addr = '0; bus1.dbg_data = '0;
    bus1.dbg_lock = 0;
    bus2.proc_req = 0; bus2.proc_wren = 0; bus2.proc_addr = '0; bus2.proc_data = '0;
    bus2.dbg_req = 0; bus2.dbg_wren = 0; bus2.dbg_addr = '0; bus2.dbg_data = '0;
    bus2.dbg_lock = 0;

    // reset held two cycles with both requesters asking
    add(1, 1, 0, 12'h123, 32'h1, 1, 1, 12'h456, 32'h2, 0, 0, 0);
    add(1, 1, 0, 12'h123, 32'h1, 1, 1, 12'h456, 32'h2, 0, 0, 0);
    // solo processor write then read
    add(0, 1, 1, 12'h0A5, 32'hDEADBEEF, 0, 0, '0, '0, 0, 1, 0);
    add(0, 1, 0, 12'h0A5, 32'h0, 0, 0, '0, '0, 0, 1, 0);
    idle(3);
    // debug preload of 0x001..0x003
    for (int i = 0; i < 3; i++) add(0, 0, 0, '0, '0, 1, 1, AW'(i + 1), rnd[i], 0, 0, 1);
    idle(1);
    // contention: debug wins only on the 5th and 10th cycle
    for (int i = 0; i < 10; i++)
      add(0, 1, 0, 12'h0A5, '0, 1, 0, 12'h001, '0, 0,
          (i != 4 && i != 9), (i == 4 || i == 9));
    idle(3);
    // lock: processor shut out, debug reads stream back to back
    for (int i = 0; i < 3; i++) add(0, 1, 0, 12'h0A5, '0, 1, 0, AW'(i + 1), '0, 1, 0, 1);
    add(0, 1, 0, 12'h0A5, '0, 0, 0, '0, '0, 1, 0, 0);
    idle(3);
    // lock raised right after a granted processor read
    add(0, 1, 0, 12'h0A5, '0, 0, 0, '0, '0, 0, 1, 0);
    add(0, 1, 0, 12'h0A5, '0, 1, 0, 12'h002, '0, 1, 0, 1);
    idle(3);
    // interleaved reads from alternating owners
    add(0, 1, 1, 12'h010, rnd[3], 0, 0, '0, '0, 0, 1, 0);
    add(0, 0, 0, '0, '0, 1, 1, 12'h020, rnd[4], 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 0, 12'h010, '0, 0, 0, '0, '0, 0, 1, 0);
      add(0, 0, 0, '0, '0, 1, 0, 12'h020, '0, 0, 0, 1);
    end
    idle(3);
    // reset while a processor read is in flight
    add(0, 1, 0, 12'h0A5, '0, 0, 0, '0, '0, 0, 1, 0);
    add(1, 1, 0, 12'h0A5, '0, 1, 0, 12'h001, '0, 0, 0, 0);
    idle(3);
    add(0, 1, 0, 12'h0A5, '0, 0, 0, '0, '0, 0, 1, 0);
    idle(3);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
